// File: rtl/lfsr_engine.sv
// Parametrised Fibonacci LFSR with serial-load mode, parallel seed load, lock-up flag and period measurement.
// Optional macro LFSR_LOCKUP_RECOVER_EN: an LFSR step from the all-zero state reloads SEED.
module lfsr_engine #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             serial_in,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] shift_reg,
   output logic             serial_out,
   output logic             lockup,
   output logic [WIDTH:0]   period,
   output logic             period_valid,
   output logic             period_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} state_t;

   localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [WIDTH:0]   period_q, period_d;
   logic             period_valid_q, period_valid_d;
   logic             period_ovf_q, period_ovf_d;
   logic             lockup_q, lockup_d;

   logic             fb;
   logic [WIDTH-1:0] step_next;
   logic [WIDTH:0]   step_num;

   assign fb        = ^(shift_reg_q & TAPS);
   assign step_next = {shift_reg_q[WIDTH-2:0], fb};
   // cnt holds the number of steps already taken since ref was captured; this step is the next one.
   assign step_num  = cnt_q + ONE;

   always_comb begin
      shift_reg_d    = shift_reg_q;
      state_d        = state_q;
      ref_d          = ref_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      period_ovf_d   = period_ovf_q;

      if (load) begin
         shift_reg_d  = seed_in;
         state_d      = S_IDLE;
         period_d     = '0;
         period_ovf_d = 1'b0;
      end else if (en) begin
         if (!mode) begin
            shift_reg_d = {shift_reg_q[WIDTH-2:0], serial_in};
            state_d     = S_IDLE;
         end else
`ifdef LFSR_LOCKUP_RECOVER_EN
         if (shift_reg_q == '0) begin
            shift_reg_d = SEED;
            state_d     = S_IDLE;
         end else
`else
         begin end
         if (mode)
`endif
         begin
            shift_reg_d = step_next;
            unique case (state_q)
               S_IDLE: begin
                  ref_d = shift_reg_q;
                  // A fixed point (e.g. the absorbing all-zero state) has period 1.
                  if (step_next == shift_reg_q) begin
                     period_d       = ONE;
                     period_valid_d = 1'b1;
                     state_d        = S_DONE;
                  end else begin
                     cnt_d   = ONE;
                     state_d = S_MEASURE;
                  end
               end
               S_MEASURE: begin
                  if (step_next == ref_q) begin
                     period_d       = step_num;
                     period_valid_d = 1'b1;
                     state_d        = S_DONE;
                  end else if (step_num == CNT_MAX) begin
                     period_d     = '0;
                     period_ovf_d = 1'b1;
                     state_d      = S_DONE;
                  end else begin
                     cnt_d = step_num;
                  end
               end
               S_DONE:  state_d = S_DONE;
               default: state_d = S_IDLE;
            endcase
         end
      end

      lockup_d = (shift_reg_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         shift_reg_q    <= SEED;
         ref_q          <= '0;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         period_ovf_q   <= 1'b0;
         lockup_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_reg_q    <= shift_reg_d;
         ref_q          <= ref_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         period_ovf_q   <= period_ovf_d;
         lockup_q       <= lockup_d;
      end
   end

   assign shift_reg    = shift_reg_q;
   assign serial_out   = shift_reg_q[WIDTH-1];
   assign lockup       = lockup_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign period_ovf   = period_ovf_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Bench for lfsr_engine: directed vectors, period pulses checked by a queue-based scoreboard monitor.
module tb_lfsr_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, mode, serial_in, load;
   logic [3:0] seed_in;

   logic [3:0] shift_reg, shift_reg2;
   logic       serial_out, serial_out2;
   logic       lockup, lockup2;
   logic [4:0] period, period2;
   logic       period_valid, period_valid2;
   logic       period_ovf, period_ovf2;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   lfsr_engine #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in(serial_in),
      .load(load), .seed_in(seed_in), .shift_reg(shift_reg), .serial_out(serial_out),
      .lockup(lockup), .period(period), .period_valid(period_valid), .period_ovf(period_ovf)
   );

   lfsr_engine #(.WIDTH(4), .TAPS(4'b0110), .SEED(4'b0001)) u_dut_ovf (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in(serial_in),
      .load(load), .seed_in(seed_in), .shift_reg(shift_reg2), .serial_out(serial_out2),
      .lockup(lockup2), .period(period2), .period_valid(period_valid2), .period_ovf(period_ovf2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step_chk(input string nm, input logic [3:0] exp);
      @(posedge clk);
      #1;
      chk(nm, int'(shift_reg), int'(exp));
   endtask

   task automatic do_load(input logic [3:0] v);
      en      = 1'b0;
      load    = 1'b1;
      seed_in = v;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Scoreboard monitor: every period_valid pulse must match the oldest expected period.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: got period_valid with period %0d, expected no pulse", period);
            end else begin
               chk("sb_period", int'(period), exp_q.pop_front());
            end
         end
      end
   end

   logic [3:0] seq   [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                              4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
   logic [3:0] ser_v [4]  = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
   logic       ser_b [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; serial_in = 1'b0; load = 1'b0; seed_in = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_shift", int'(shift_reg), 1);
      chk("rst_serial_out", int'(serial_out), 0);
      chk("rst_lockup", int'(lockup), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_valid", int'(period_valid), 0);
      chk("rst_ovf", int'(period_ovf), 0);

      // Serial shift-in
      mode = 1'b0;
      en   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         serial_in = ser_b[i];
         step_chk("serial_shift", ser_v[i]);
      end
      chk("serial_out_msb", int'(serial_out), 1);
      chk("serial_no_valid", int'(period_valid), 0);

      // Full maximal-length sequence
      do_load(4'b0001);
      chk("load_seed", int'(shift_reg), 1);
      mode = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 14) exp_q.push_back(15);
         step_chk("lfsr_seq", seq[i]);
      end
      chk("seq_period", int'(period), 15);
      chk("seq_valid", int'(period_valid), 1);

      // Enable dropped mid-sequence
      do_load(4'b0001);
      chk("load_clears_period", int'(period), 0);
      mode = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 5; i++) step_chk("pre_freeze", seq[i]);
      en = 1'b0;
      for (int i = 0; i < 5; i++) step_chk("frozen", 4'b0110);
      en = 1'b1;
      for (int i = 5; i < 15; i++) begin
         if (i == 14) exp_q.push_back(15);
         step_chk("post_freeze", seq[i]);
      end
      chk("freeze_period", int'(period), 15);

      // load and en together: load wins, no step
      mode    = 1'b1;
      en      = 1'b1;
      load    = 1'b1;
      seed_in = 4'b1010;
      @(posedge clk);
      #1;
      load = 1'b0;
      en   = 1'b0;
      chk("load_beats_en", int'(shift_reg), 10);

      // All-zero state
      do_load(4'b0000);
      chk("zero_loaded", int'(shift_reg), 0);
      chk("zero_lockup", int'(lockup), 1);
      mode = 1'b1;
      en   = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
      step_chk("recover_seed", 4'b0001);
      chk("recover_lockup", int'(lockup), 0);
`else
      exp_q.push_back(1);
      step_chk("zero_absorb", 4'b0000);
      chk("zero_lockup_hold", int'(lockup), 1);
      chk("zero_period", int'(period), 1);
`endif
      en = 1'b0;

      // Async reset after a completed measurement
      do_load(4'b0001);
      mode = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 14) exp_q.push_back(15);
         step_chk("pre_reset_seq", seq[i]);
      end
      for (int i = 0; i < 3; i++) step_chk("done_runs", seq[i]);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_shift", int'(shift_reg), 1);
      chk("async_rst_period", int'(period), 0);
      chk("async_rst_lockup", int'(lockup), 0);
      en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Non-invertible taps on the second instance
      do_load(4'b0001);
      mode = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 14) exp_q.push_back(15);
         @(posedge clk);
         #1;
      end
      chk("ovf_not_yet", int'(period_ovf2), 0);
      @(posedge clk);
      #1;
      en = 1'b0;
      chk("ovf_shift", int'(shift_reg2), 5);
      chk("ovf_flag", int'(period_ovf2), 1);
      chk("ovf_period", int'(period2), 0);
      do_load(4'b0011);
      chk("ovf_cleared", int'(period_ovf2), 0);
      chk("ovf_load_shift", int'(shift_reg2), 3);

      @(posedge clk);
      @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
